// File: rtl/ibex_pkg.sv
// Shared types for the multiply/divide sequencing controller.
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  typedef enum logic [1:0] {
    MD_CTRL_IDLE,
    MD_CTRL_RUN,
    MD_CTRL_DRAIN,
    MD_CTRL_RESP
  } md_ctrl_state_e;

  typedef struct packed {
    md_op_e      op;
    logic [1:0]  signed_mode;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } md_key_t;

  localparam int unsigned MdKeyW = $bits(md_key_t);

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

endpackage

// File: rtl/ibex_md_result_cache.sv
// One-entry cache of the most recent DIV/REM result, keyed on the full request.
module ibex_md_result_cache
  import ibex_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              lookup_i,
  input  logic [MdKeyW-1:0] lookup_key_i,
  input  logic              write_i,
  input  logic [MdKeyW-1:0] write_key_i,
  input  logic [31:0]       write_data_i,
  input  logic              flush_i,
  output logic              hit_o,
  output logic [31:0]       rdata_o
);

  logic              valid_q;
  logic [MdKeyW-1:0] key_q;
  logic [31:0]       data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      key_q   <= '0;
      data_q  <= '0;
    end else begin
      // A coincident flush overrides the write, so a stale entry never survives.
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (write_i) begin
        valid_q <= 1'b1;
      end
      if (write_i) begin
        key_q  <= write_key_i;
        data_q <= write_data_i;
      end
    end
  end

  assign hit_o   = lookup_i & valid_q & (key_q == lookup_key_i);
  assign rdata_o = data_q;

endmodule

// File: rtl/ibex_multdiv_ctrl.sv
// Request sequencing, adder sharing and kill draining for the iterative multiply/divide unit.
module ibex_multdiv_ctrl
  import ibex_pkg::*;
#(
  parameter bit ResultCache = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  md_op_e      operator_i,
  input  logic [1:0]  signed_mode_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  input  logic        cache_flush_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        md_mult_en_o,
  output logic        md_div_en_o,
  output md_op_e      md_operator_o,
  output logic [1:0]  md_signed_mode_o,
  output logic [31:0] md_op_a_o,
  output logic [31:0] md_op_b_o,
  input  logic        md_valid_i,
  input  logic [31:0] md_result_i,
  input  logic        alu_req_i,
  output logic        adder_sel_md_o,
  output logic        alu_stall_o
);

  md_ctrl_state_e state_q;
  md_key_t        req_key;
  md_key_t        held_key;
  logic           accept;
  logic           busy;
  logic           cache_lookup;
  logic           cache_write;
  logic           cache_hit;
  logic [31:0]    cache_rdata;

  assign req_key  = '{op: operator_i, signed_mode: signed_mode_i, op_a: op_a_i, op_b: op_b_i};
  assign held_key = '{op: md_operator_o, signed_mode: md_signed_mode_o,
                      op_a: md_op_a_o, op_b: md_op_b_o};

  assign accept       = req_i & ready_o & ~kill_i;
  assign cache_lookup = md_is_div(operator_i);
  assign cache_write  = (state_q == MD_CTRL_RUN) & md_valid_i & ~kill_i & md_is_div(md_operator_o);

  generate
    if (ResultCache) begin : g_cache
      ibex_md_result_cache u_cache (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .lookup_i     (cache_lookup),
        .lookup_key_i (req_key),
        .write_i      (cache_write),
        .write_key_i  (held_key),
        .write_data_i (md_result_i),
        .flush_i      (cache_flush_i),
        .hit_o        (cache_hit),
        .rdata_o      (cache_rdata)
      );
    end else begin : g_no_cache
      assign cache_hit   = 1'b0;
      assign cache_rdata = '0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= MD_CTRL_IDLE;
      md_operator_o    <= MD_OP_MULL;
      md_signed_mode_o <= '0;
      md_op_a_o        <= '0;
      md_op_b_o        <= '0;
      result_o         <= '0;
    end else begin
      unique case (state_q)
        MD_CTRL_IDLE: begin
          if (accept) begin
            md_operator_o    <= operator_i;
            md_signed_mode_o <= signed_mode_i;
            md_op_a_o        <= op_a_i;
            md_op_b_o        <= op_b_i;
            if (cache_hit) begin
              result_o <= cache_rdata;
              state_q  <= MD_CTRL_RESP;
            end else begin
              state_q  <= MD_CTRL_RUN;
            end
          end
        end
        MD_CTRL_RUN: begin
          // The unit has no abort, so a kill keeps it enabled until it finishes.
          if (kill_i) begin
            state_q <= md_valid_i ? MD_CTRL_IDLE : MD_CTRL_DRAIN;
          end else if (md_valid_i) begin
            result_o <= md_result_i;
            state_q  <= MD_CTRL_RESP;
          end
        end
        MD_CTRL_DRAIN: begin
          if (md_valid_i) begin
            state_q <= MD_CTRL_IDLE;
          end
        end
        MD_CTRL_RESP: state_q <= MD_CTRL_IDLE;
        default:      state_q <= MD_CTRL_IDLE;
      endcase
    end
  end

  assign busy           = (state_q == MD_CTRL_RUN) | (state_q == MD_CTRL_DRAIN);
  assign ready_o        = (state_q == MD_CTRL_IDLE);
  assign done_o         = (state_q == MD_CTRL_RESP) & ~kill_i;
  assign md_mult_en_o   = busy & ~md_is_div(md_operator_o);
  assign md_div_en_o    = busy & md_is_div(md_operator_o);
  assign adder_sel_md_o = busy;
  assign alu_stall_o    = alu_req_i & adder_sel_md_o;

endmodule
